// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              epoch;
  } fetch_tag_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, execute redirect and decode handshake.
interface inst_fetch_unit_if;

  logic                        imem_req_valid;
  logic [fetch_pkg::ADDR_W-1:0] imem_req_addr;
  logic [fetch_pkg::DATA_W-1:0] imem_resp_data;
  logic                        redirect_valid;
  logic [fetch_pkg::ADDR_W-1:0] redirect_pc;
  logic                        if_valid;
  logic                        if_ready;
  logic [fetch_pkg::ADDR_W-1:0] if_pc;
  logic [fetch_pkg::DATA_W-1:0] if_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign occ     = cnt_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Flush has priority over a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cnt_q <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: owns the fetch PC, issues credit-limited imem requests tagged with an epoch,
// buffers in-epoch responses and presents them to decode.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IMEM_LAT   = 1,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_unit_if.master fetch
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              epoch_q, epoch_d;
  fetch_tag_t        tag_q [IMEM_LAT];
  fetch_tag_t        tag_exit;

  logic [CNT_W-1:0]  occ;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              issue;
  logic              push;
  logic              pop;
  logic              redirect;
  int unsigned       inflight;
  int unsigned       credit_used;

  assign redirect = fetch.redirect_valid;
  assign tag_exit = tag_q[IMEM_LAT-1];

  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(IMEM_LAT); i++) begin
      if (tag_q[i].valid) begin
        inflight = inflight + 1;
      end
    end
  end

  assign pop         = fetch.if_valid & fetch.if_ready;
  // Exiting tag is still counted: its slot is only freed once it lands or is dropped.
  assign credit_used = 32'(occ) + inflight - 32'(pop);
  assign issue       = ~reset & ~redirect & (credit_used < FIFO_DEPTH);

  // Stale-epoch responses are dropped here; their credit frees as the tag leaves.
  assign push             = tag_exit.valid & (tag_exit.epoch == epoch_q) & ~redirect;
  assign push_entry.pc    = tag_exit.pc;
  assign push_entry.instr = fetch.imem_resp_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (redirect) begin
      fetch_pc_d = align_pc(fetch.redirect_pc);
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(IMEM_LAT); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: issue, pc: fetch_pc_q, epoch: epoch_q};
      for (int i = 1; i < int'(IMEM_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .occ       (occ)
  );

  assign fetch.imem_req_valid = issue;
  assign fetch.imem_req_addr  = fetch_pc_q;
  assign fetch.if_valid       = ~reset & ~fifo_empty;
  assign fetch.if_pc          = fifo_head.pc;
  assign fetch.if_instr       = fifo_head.instr;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle instruction memory where mem[i] = 0x1000 + i.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_LAT   (1),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fetch (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0]  reqs [$];
  fetch_entry_t dels [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    bus.imem_resp_data <= bus.imem_req_valid ? mem_word(bus.imem_req_addr) : 32'hDEAD_BEEF;
  end

  // Record issued requests and genuine deliveries (redirect-cycle handshakes are discards).
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!reset) begin
      if (bus.imem_req_valid) reqs.push_back(bus.imem_req_addr);
      if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
        e.pc    = bus.if_pc;
        e.instr = bus.if_instr;
        dels.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic ready);
    cyc();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready = ready;
    cyc();
    cyc();
    reset = 1'b0;
    reqs.delete();
    dels.delete();
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready = 1'b1;
    cyc();
    cyc();
    #2;
    checks++;
    if (bus.if_valid !== 1'b0) begin
      failures++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid);
    end
  endtask

  task automatic test_stream();
    start_stream(1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin cyc(); #2; end
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * k)) begin
        failures++;
        $display("FAIL stream_req%0d got=%b/%h exp=1/%h", k, bus.imem_req_valid,
                 bus.imem_req_addr, 32'(4 * k));
      end
      checks++;
      if (k < 2) begin
        if (bus.if_valid !== 1'b0) begin
          failures++; $display("FAIL stream_early_valid%0d got=%b exp=0", k, bus.if_valid);
        end
      end else if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * (k - 2)) ||
                   bus.if_instr !== 32'(32'h1000 + k - 2)) begin
        failures++;
        $display("FAIL stream_out%0d got=%b/%h/%h exp=1/%h/%h", k, bus.if_valid, bus.if_pc,
                 bus.if_instr, 32'(4 * (k - 2)), 32'(32'h1000 + k - 2));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_req = 5'b00011;
    start_stream(1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); #2; end
      checks++;
      if (bus.imem_req_valid !== exp_req[k]) begin
        failures++;
        $display("FAIL bp_req_valid%0d got=%b exp=%b", k, bus.imem_req_valid, exp_req[k]);
      end
      if (k >= 2) begin
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h1000) begin
          failures++;
          $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/0/1000", k, bus.if_valid, bus.if_pc,
                   bus.if_instr);
        end
      end
    end
    cyc();
    bus.if_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    #2;
    checks++;
    if (dels.size() < 3) begin
      failures++; $display("FAIL bp_del_count got=%0d exp>=3", dels.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dels[i].pc !== 32'(4 * i) || dels[i].instr !== 32'(32'h1000 + i)) begin
          failures++;
          $display("FAIL bp_del%0d got=%h/%h exp=%h/%h", i, dels[i].pc, dels[i].instr,
                   32'(4 * i), 32'(32'h1000 + i));
        end
      end
    end
    checks++;
    if (reqs.size() < 3 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4 || reqs[2] !== 32'h8) begin
      failures++; $display("FAIL bp_req_order got_size=%0d exp=0,4,8", reqs.size());
    end
  endtask

  task automatic test_redirect();
    start_stream(1'b1);
    cyc(); cyc(); #2;
    checks++;
    if (bus.imem_req_addr !== 32'h8) begin
      failures++; $display("FAIL rd_pre_addr got=%h exp=8", bus.imem_req_addr);
    end
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rd_cycle_req got=%b exp=0", bus.imem_req_valid);
    end
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.if_valid !== 1'b0) begin
      failures++; $display("FAIL rd_next_valid got=%b exp=0", bus.if_valid);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL rd_target_req got=%b/%h exp=1/100", bus.imem_req_valid, bus.imem_req_addr);
    end
    cyc(); cyc(); #2;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== 32'h1040) begin
      failures++;
      $display("FAIL rd_target_out got=%b/%h/%h exp=1/100/1040", bus.if_valid, bus.if_pc,
               bus.if_instr);
    end
    cyc(); #2;
    checks++;
    if (dels.size() !== 2 || dels[0].pc !== 32'h0 || dels[1].pc !== 32'h100) begin
      failures++; $display("FAIL rd_del_seq got_size=%0d exp=2 (0,100)", dels.size());
    end
  endtask

  task automatic test_align_wrap();
    start_stream(1'b1);
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL aw_align got=%b/%h exp=1/100", bus.imem_req_valid, bus.imem_req_addr);
    end
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL aw_top got=%b/%h exp=1/fffffffc", bus.imem_req_valid, bus.imem_req_addr);
    end
    cyc(); #2;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL aw_wrap got=%b/%h exp=1/0", bus.imem_req_valid, bus.imem_req_addr);
    end
    cyc(); #2;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || bus.if_instr !== 32'h4000_0FFF) begin
      failures++;
      $display("FAIL aw_top_out got=%b/%h/%h exp=1/fffffffc/40000fff", bus.if_valid, bus.if_pc,
               bus.if_instr);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    start_stream(1'b1);
    cyc(); cyc(); cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    #2;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin
      failures++; $display("FAIL bb_head_pre got=%b/%h exp=1/4", bus.if_valid, bus.if_pc);
    end
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_addr !== 32'h200) begin
      failures++; $display("FAIL bb_after got=%b/%h exp=0/200", bus.if_valid, bus.imem_req_addr);
    end
    cyc(); cyc(); #2;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_instr !== 32'h1080) begin
      failures++;
      $display("FAIL bb_target got=%b/%h/%h exp=1/200/1080", bus.if_valid, bus.if_pc, bus.if_instr);
    end
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    cyc();
    bus.redirect_pc = 32'h400;
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL bb_second_req got=%b exp=0", bus.imem_req_valid);
    end
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h400) begin
      failures++;
      $display("FAIL bb_last_wins got=%b/%b/%h exp=0/1/400", bus.if_valid, bus.imem_req_valid,
               bus.imem_req_addr);
    end
    cyc(); cyc(); #2;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h400 || bus.if_instr !== 32'h1100) begin
      failures++;
      $display("FAIL bb_last_out got=%b/%h/%h exp=1/400/1100", bus.if_valid, bus.if_pc,
               bus.if_instr);
    end
    bad = 0;
    foreach (reqs[i]) if (reqs[i] == 32'h300) bad++;
    foreach (dels[i]) if (dels[i].pc == 32'h4 || dels[i].pc == 32'h300) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL bb_stale_seen got=%0d exp=0", bad);
    end
  endtask

  task automatic test_mid_reset();
    start_stream(1'b1);
    cyc(); cyc(); cyc();
    reset = 1'b1;
    #2;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mr_during got=%b/%b exp=0/0", bus.if_valid, bus.imem_req_valid);
    end
    reqs.delete();
    dels.delete();
    cyc();
    reset = 1'b0;
    #2;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL mr_restart got=%b/%b/%h exp=0/1/0", bus.if_valid, bus.imem_req_valid,
               bus.imem_req_addr);
    end
    cyc(); cyc(); cyc(); cyc(); #2;
    checks++;
    if (dels.size() !== 2 || dels[0].pc !== 32'h0 || dels[0].instr !== 32'h1000 ||
        dels[1].pc !== 32'h4) begin
      failures++; $display("FAIL mr_del_seq got_size=%0d exp=2 (0,4)", dels.size());
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
